acs_butterfly_pm: RTL and testbench
===================================

# acs_butterfly_pm

Add-compare-select butterfly with registered path metrics for the hard-decision rate-1/2 Viterbi decoder. It sits directly downstream of the per-butterfly branch metric units and consumes their two 2-bit metrics, `path_0_bmc` and `path_1_bmc`. Each trellis step it updates the path metrics of one state pair (2j, 2j+1) from predecessors j (a) and j+N/2 (b). It emits one survivor decision bit per state to the traceback memory and supports saturation detection and global normalization.

## Interface
- `PM_W`, 8, path metric width in bits (≥ 4)
- `LO_INIT`, 0, value loaded into `pm_lo` on reset/start
- `HI_INIT`, 32, value loaded into `pm_hi` on reset/start (must fit in `PM_W`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  frame start; reloads init metrics
- `bm_valid`  in  1  branch metrics and predecessor metrics valid this cycle
- `path_0_bmc`  in  2  branch metric, hypothesis 0 (range 0..2)
- `path_1_bmc`  in  2  branch metric, hypothesis 1 (range 0..2)
- `pm_in_a`  in  PM_W  path metric of predecessor a
- `pm_in_b`  in  PM_W  path metric of predecessor b
- `norm_sub`  in  1  subtract 2^(PM_W-1) from this step's results (global, from controller)
- `pm_lo`  out  PM_W  registered metric, state 2j
- `pm_hi`  out  PM_W  registered metric, state 2j+1
- `pm_msb`  out  1  `pm_lo[PM_W-1] & pm_hi[PM_W-1]`, for the controller's normalization AND-tree
- `dec_lo`  out  1  survivor decision, state 2j (1 = predecessor b)
- `dec_hi`  out  1  survivor decision, state 2j+1
- `dec_valid`  out  1  decisions valid (1-cycle pulse)
- `sat_flag`  out  1  sticky: a saturation occurred since last start

## Operation
- Candidates are computed in PM_W+1 bits, zero-extended:
  - lo: ca = `pm_in_a` + `path_0_bmc`; cb = `pm_in_b` + `path_1_bmc`
  - hi: ca = `pm_in_a` + `path_1_bmc`; cb = `pm_in_b` + `path_0_bmc`
- Select:
  - dec = 1 iff cb < ca (strict); a tie selects a, dec = 0.
  - Winner w = min(ca, cb), taken on the full PM_W+1 values.
- Normalize: if `norm_sub`, w' = w − 2^(PM_W-1); otherwise w' = w. The controller guarantees `norm_sub` only when all predecessor MSBs are set, so no underflow occurs.
- Saturate: if w' > 2^PM_W − 1, the stored metric = all-ones and `sat_flag` sets.
- Priority per cycle: `start` > `bm_valid` > hold.
  - On `start`: `pm_lo` = `LO_INIT`, `pm_hi` = `HI_INIT`, `sat_flag` = 0, `dec_valid` = 0, decisions unchanged.
  - `bm_valid` in the same cycle as `start` is discarded.
- When `bm_valid` = 0 and `start` = 0: metrics, decisions and `sat_flag` hold; `dec_valid` = 0.
- Branch metric inputs of 3 are out of spec. They are used arithmetically as-is; no check is made.

## Timing
- Reset (async assert, sync release by top level):
  - `pm_lo` = `LO_INIT`, `pm_hi` = `HI_INIT`
  - `dec_lo` = `dec_hi` = 0, `dec_valid` = 0, `sat_flag` = 0
  - `pm_msb` follows the reset metrics.
- Latency 1: inputs sampled at edge k with `bm_valid` = 1 → `pm_lo`, `pm_hi`, `dec_*` updated and `dec_valid` = 1 after edge k.
- `dec_valid` is deasserted the next cycle unless `bm_valid` is held.
- Back-to-back `bm_valid` accepted every cycle; no backpressure.
- `pm_in_a`/`pm_in_b` are combinationally wired from other butterflies' `pm_lo`/`pm_hi` registers. The block adds no combinational path from any input to any output.
- `rst_n` asserted mid-frame: all outputs take reset values immediately (asynchronously), regardless of clock.

## Test plan
- Reset/start: drive `rst_n` low → `pm_lo` = 0, `pm_hi` = 32, `dec_valid` = 0. Release, pulse `start` with `bm_valid` = 1 → same values, `dec_valid` stays 0.
- Basic ACS: `pm_in_a` = 10, `pm_in_b` = 7, `path_0_bmc` = 2, `path_1_bmc` = 0 → next cycle `pm_lo` = 7, `dec_lo` = 1, `pm_hi` = 9, `dec_hi` = 1, `dec_valid` = 1 for exactly one cycle.
- Tie: a = b = 5, both bmc = 1 → `pm_lo` = `pm_hi` = 6, `dec_lo` = `dec_hi` = 0.
- Normalization: a = 200, b = 130, bmc0 = 0, bmc1 = 2, `norm_sub` = 1 → `pm_lo` = 4 (dec 1), `pm_hi` = 2 (dec 1), `pm_msb` = 0.
- Saturation: a = 255, b = 254, both bmc = 2, `norm_sub` = 0 → `pm_lo` = `pm_hi` = 255, decisions = 1, `sat_flag` = 1 and stays 1 until the next `start`.
- Hold/reset mid-stream: 4 consecutive `bm_valid` steps, then `bm_valid` = 0 for 3 cycles → outputs hold, `dec_valid` = 0. Then async `rst_n` pulse between edges → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/acs_butterfly_pm.sv
`default_nettype none
// ============================================================================
// Module   : acs_butterfly_pm
// Purpose  : Add-compare-select butterfly with registered, saturating path
//            metrics and survivor decisions for a rate-1/2 Viterbi decoder.
// Revision : 1.0 - initial release
// ============================================================================
module acs_butterfly_pm #(
    parameter int PM_W    = 8,
    parameter int LO_INIT = 0,
    parameter int HI_INIT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            bm_valid,
    input  logic [1:0]      path_0_bmc,
    input  logic [1:0]      path_1_bmc,
    input  logic [PM_W-1:0] pm_in_a,
    input  logic [PM_W-1:0] pm_in_b,
    input  logic            norm_sub,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            pm_msb,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            dec_valid,
    output logic            sat_flag
);

    localparam logic [PM_W:0]   c_HALF    = {2'b01, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] c_LO_INIT = PM_W'(LO_INIT);
    localparam logic [PM_W-1:0] c_HI_INIT = PM_W'(HI_INIT);

    // Index 0 is state 2j (lo), index 1 is state 2j+1 (hi)
    logic [PM_W-1:0] w_pm_next  [2];
    logic            w_dec_next [2];
    logic            w_sat_next [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_acs
            logic [1:0]    w_bm_a;
            logic [1:0]    w_bm_b;
            logic [PM_W:0] w_ca;
            logic [PM_W:0] w_cb;
            logic [PM_W:0] w_win;
            logic [PM_W:0] w_norm;

            // The hi state swaps which hypothesis metric feeds each branch
            assign w_bm_a = (g == 0) ? path_0_bmc : path_1_bmc;
            assign w_bm_b = (g == 0) ? path_1_bmc : path_0_bmc;

            assign w_ca   = {1'b0, pm_in_a} + {{(PM_W-1){1'b0}}, w_bm_a};
            assign w_cb   = {1'b0, pm_in_b} + {{(PM_W-1){1'b0}}, w_bm_b};
            assign w_dec_next[g] = (w_cb < w_ca);
            assign w_win  = w_dec_next[g] ? w_cb : w_ca;
            assign w_norm = norm_sub ? (w_win - c_HALF) : w_win;

            assign w_sat_next[g] = w_norm[PM_W];
            assign w_pm_next[g]  = w_norm[PM_W] ? {PM_W{1'b1}} : w_norm[PM_W-1:0];
        end
    endgenerate

    logic [PM_W-1:0] r_pm_lo;
    logic [PM_W-1:0] r_pm_hi;
    logic            r_dec_lo;
    logic            r_dec_hi;
    logic            r_dec_valid;
    logic            r_sat_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pm_lo     <= c_LO_INIT;
            r_pm_hi     <= c_HI_INIT;
            r_dec_lo    <= 1'b0;
            r_dec_hi    <= 1'b0;
            r_dec_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else if (start) begin
            r_pm_lo     <= c_LO_INIT;
            r_pm_hi     <= c_HI_INIT;
            r_dec_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else if (bm_valid) begin
            r_pm_lo     <= w_pm_next[0];
            r_pm_hi     <= w_pm_next[1];
            r_dec_lo    <= w_dec_next[0];
            r_dec_hi    <= w_dec_next[1];
            r_dec_valid <= 1'b1;
            r_sat_flag  <= r_sat_flag | w_sat_next[0] | w_sat_next[1];
        end else begin
            r_dec_valid <= 1'b0;
        end
    end

    assign pm_lo     = r_pm_lo;
    assign pm_hi     = r_pm_hi;
    assign pm_msb    = r_pm_lo[PM_W-1] & r_pm_hi[PM_W-1];
    assign dec_lo    = r_dec_lo;
    assign dec_hi    = r_dec_hi;
    assign dec_valid = r_dec_valid;
    assign sat_flag  = r_sat_flag;

endmodule
`default_nettype wire

// File: tb/tb_acs_butterfly_pm.sv
`default_nettype none
// ============================================================================
// Module   : tb_acs_butterfly_pm
// Purpose  : Directed, table-driven self-checking bench for acs_butterfly_pm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acs_butterfly_pm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bm_valid = 1'b0;
    logic [1:0] path_0_bmc = 2'd0;
    logic [1:0] path_1_bmc = 2'd0;
    logic [7:0] pm_in_a = 8'd0;
    logic [7:0] pm_in_b = 8'd0;
    logic       norm_sub = 1'b0;
    logic [7:0] pm_lo;
    logic [7:0] pm_hi;
    logic       pm_msb;
    logic       dec_lo;
    logic       dec_hi;
    logic       dec_valid;
    logic       sat_flag;

    int checks = 0;
    int errors = 0;

    acs_butterfly_pm #(.PM_W(8), .LO_INIT(0), .HI_INIT(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bm_valid   (bm_valid),
        .path_0_bmc (path_0_bmc),
        .path_1_bmc (path_1_bmc),
        .pm_in_a    (pm_in_a),
        .pm_in_b    (pm_in_b),
        .norm_sub   (norm_sub),
        .pm_lo      (pm_lo),
        .pm_hi      (pm_hi),
        .pm_msb     (pm_msb),
        .dec_lo     (dec_lo),
        .dec_hi     (dec_hi),
        .dec_valid  (dec_valid),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] bm0;
        logic [1:0] bm1;
        logic       norm;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       dlo;
        logic       dhi;
        logic       msb;
        logic       sat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                           input logic dlo, input logic dhi, input logic dv,
                           input logic msb, input logic sat);
        chk({tag, ".pm_lo"},     32'(pm_lo),     32'(lo));
        chk({tag, ".pm_hi"},     32'(pm_hi),     32'(hi));
        chk({tag, ".dec_lo"},    32'(dec_lo),    32'(dlo));
        chk({tag, ".dec_hi"},    32'(dec_hi),    32'(dhi));
        chk({tag, ".dec_valid"}, 32'(dec_valid), 32'(dv));
        chk({tag, ".pm_msb"},    32'(pm_msb),    32'(msb));
        chk({tag, ".sat_flag"},  32'(sat_flag),  32'(sat));
    endtask

    task automatic drive(input vec_t v);
        pm_in_a    = v.a;
        pm_in_b    = v.b;
        path_0_bmc = v.bm0;
        path_1_bmc = v.bm1;
        norm_sub   = v.norm;
        bm_valid   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           a     b     bm0   bm1   norm  lo    hi    dlo   dhi   msb   sat
        vecs[0] = '{8'd10,  8'd7,   2'd2, 2'd0, 1'b0, 8'd7,   8'd9,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd5,   2'd1, 2'd1, 1'b0, 8'd6,   8'd6,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'd200, 8'd130, 2'd0, 2'd2, 1'b1, 8'd4,   8'd2,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'd3,   8'd20,  2'd0, 2'd2, 1'b0, 8'd3,   8'd5,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'd150, 8'd140, 2'd1, 2'd1, 1'b0, 8'd141, 8'd141, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'd10,  8'd8,   2'd0, 2'd2, 1'b0, 8'd10,  8'd8,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'd255, 8'd254, 2'd2, 2'd2, 1'b0, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state
        #12;
        chk_all("reset", 8'd0, 8'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // start wins over bm_valid in the same cycle
        drive(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bm_valid = 1'b0;
        chk_all("start_bmv", 8'd0, 8'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table vectors, each separated by an idle cycle
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            bm_valid = 1'b0;
            chk_all($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].dlo,
                    vecs[i].dhi, 1'b1, vecs[i].msb, vecs[i].sat);
            @(negedge clk);
            chk($sformatf("vec%0d.dv_drop", i), 32'(dec_valid), 32'd0);
        end

        // Sticky saturation survives a non-saturating step
        drive(vecs[1]);
        @(negedge clk);
        bm_valid = 1'b0;
        chk_all("sat_sticky", 8'd6, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // start clears sat and metrics but keeps decisions
        drive(vecs[0]);
        @(negedge clk);
        bm_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_all("start_clr", 8'd0, 8'd32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Four back-to-back steps keep dec_valid high
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk_all($sformatf("b2b%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].dlo,
                    vecs[i].dhi, 1'b1, vecs[i].msb, vecs[i].sat);
        end
        bm_valid = 1'b0;
        pm_in_a = 8'd99;
        pm_in_b = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all($sformatf("hold%0d", i), 8'd3, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges, observed before the next posedge
        drive(vecs[4]);
        @(negedge clk);
        bm_valid = 1'b0;
        chk_all("pre_rst", 8'd141, 8'd141, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'd0, 8'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_rst", 8'd0, 8'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
